// File: rtl/mul_booth_seq_if.sv
// Operand/result handshake bundle for the sequential Booth multiplier.
interface mul_booth_seq_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 tc;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, tc, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, tc, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, signed or unsigned per operation.
// state | meaning:  IDLE | accepting operands,  CALC | retiring Booth digits,  DONE | holding result
module mul_booth_seq #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  mul_booth_seq_if.slave bus
);
  localparam int HW = WIDTH + 4;      // extended operand plus room for +-2M
  localparam int N  = WIDTH / 2 + 1;
  localparam int BW = 2 * N + 1;      // extended multiplier plus implicit zero below LSB
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [HW-1:0]        mcand;
  logic [HW-1:0]        hi;
  logic [BW-1:0]        lo;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [HW-1:0]        pp;
  logic [HW-1:0]        sum;
  logic [HW-1:0]        hi_nx;
  logic [BW-1:0]        lo_nx;
  logic [2*WIDTH-1:0]   product_nx;

  always_comb begin
    pp = '0;
    case (lo[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    sum        = hi + pp;
    hi_nx      = {{2{sum[HW-1]}}, sum[HW-1:2]};
    lo_nx      = {sum[1:0], lo[BW-1:2]};
    // Low product bits live in the shifted-down multiplier register, the rest in hi.
    product_nx = {hi_nx[WIDTH-3:0], lo_nx[BW-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      cnt         <= '0;
      mcand       <= '0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand      <= {{4{bus.tc & bus.a[WIDTH-1]}}, bus.a};
            lo         <= {{2{bus.tc & bus.b[WIDTH-1]}}, bus.b, 1'b0};
            hi         <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            product_q   <= product_nx;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
endmodule

// File: tb/tb_mul_booth_seq.sv
// Scoreboard bench for mul_booth_seq: directed vectors, backpressure, async abort, back-to-back stream.
module tb_mul_booth_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_booth_seq_if #(.WIDTH(W)) bus ();
  mul_booth_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [2*W-1:0] sb[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("unexpected_result", {32'h0, bus.product}, 64'hFFFF_FFFF_FFFF_FFFF);
      else check("product", {32'h0, bus.product}, {32'h0, sb.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int k = 0;
    while (!bus.in_ready && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic issue(input bit t, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2*W-1:0] e, input bit push);
    wait_ready();
    bus.tc = t; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [2*W-1:0] model(input bit t, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe, ye;
    xe = t ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ye = t ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  initial begin
    int k;
    bit t;
    logic [W-1:0] x, y;
    bus.in_valid = 1'b0; bus.tc = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;

    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_product", bus.product, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency: out_valid exactly 9 edges after acceptance, in_ready low throughout.
    issue(1'b1, 16'hBA86, 16'h794D, 32'hDF14704E, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      check("in_ready_busy", bus.in_ready, 0);
      @(posedge clk); #1;
      check("out_valid_latency", bus.out_valid, (i == 9) ? 1 : 0);
    end

    issue(1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1);
    issue(1'b1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD, 1'b1);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    issue(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b1);
    issue(1'b0, 16'h0000, 16'h1234, 32'h00000000, 1'b1);
    issue(1'b0, 16'h8000, 16'h0002, 32'h00010000, 1'b1);

    // Backpressure: result held, new operands ignored.
    wait_ready();
    bus.out_ready = 1'b0;
    issue(1'b0, 16'h0100, 16'h0020, 32'h00002000, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_out_valid", bus.out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1; bus.tc = 1'b1; bus.a = 16'hAAAA + 16'(i); bus.b = 16'h5555;
      @(posedge clk); #1;
      check("bp_product_hold", bus.product, 32'h00002000);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid_hold", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);
    issue(1'b1, 16'h0003, 16'hFFFB, 32'hFFFFFFF1, 1'b1);

    // Async abort during CALC step 4; aborted op produces nothing.
    wait_ready();
    issue(1'b1, 16'h7FFF, 16'h7FFF, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_product", bus.product, 0);
    check("abort_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(1'b1, 16'h0007, 16'hFFFE, 32'hFFFFFFF2, 1'b1);

    // Back-to-back stream with in_valid and out_ready held high.
    wait_ready();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      t = 1'($urandom_range(0, 1));
      x = W'($urandom);
      y = W'($urandom);
      bus.tc = t; bus.a = x; bus.b = y;
      sb.push_back(model(t, x, y));
      @(posedge clk); #1;
      bus.tc = ~t; bus.a = ~x; bus.b = y ^ 16'h1234;
      k = 0;
      while (!bus.in_ready && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      check("op_period", k + 1, 11);
    end
    bus.in_valid = 1'b0;

    repeat (3) @(posedge clk); #1;
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
